// File: rtl/counter_strobe_multi.sv
`default_nettype none
// ============================================================================
// counter_strobe_multi : CHANNELS independent tick counters with programmable
//                        period, periodic/one-shot mode and a strobe delayed
//                        LATENCY cycles after each completing tick.
// Revision            : 1.0
// ============================================================================
module counter_strobe_multi #(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  parameter  int LATENCY  = 2,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] tick_i,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [CH_W-1:0]     cfg_ch_i,
  input  logic [WIDTH-1:0]    cfg_period_i,
  input  logic                cfg_oneshot_i,
  output logic [CHANNELS-1:0] strobe_o,
  output logic [CHANNELS-1:0] armed_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic cfg_ready_q;
  logic cfg_fire;

  // Ready comes up one cycle after reset is released and then stays high.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_ready_q <= 1'b0;
    end else begin
      cfg_ready_q <= 1'b1;
    end
  end

  assign cfg_ready_o = cfg_ready_q;
  assign cfg_fire    = cfg_valid_i && cfg_ready_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    localparam logic [CH_W-1:0] C_IDX = CH_W'(c);

    logic [0:0]         state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   period_q, period_d;
    logic               oneshot_q, oneshot_d;
    logic [LATENCY-1:0] pipe_q, pipe_d;
    logic [WIDTH-1:0]   count_inc;
    logic               sel;
    logic               cnt_en;
    logic               complete;
    logic               pipe_in;

    assign sel       = cfg_fire && (cfg_ch_i == C_IDX);
    assign count_inc = count_q + WIDTH'(1);
    assign cnt_en    = (state_q == ST_RUN) && tick_i[c];
    assign complete  = cnt_en && (count_inc == period_q);

    // A configuration write takes priority over a same-cycle tick.
    always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      period_d  = period_q;
      oneshot_d = oneshot_q;
      pipe_in   = 1'b0;
      if (sel) begin
        period_d  = cfg_period_i;
        oneshot_d = cfg_oneshot_i;
        count_d   = '0;
        state_d   = (cfg_period_i != '0) ? ST_RUN : ST_IDLE;
      end else if (cnt_en) begin
        if (complete) begin
          count_d = '0;
          pipe_in = 1'b1;
          if (oneshot_q) begin
            state_d = ST_IDLE;
          end
        end else begin
          count_d = count_inc;
        end
      end
    end

    if (LATENCY == 1) begin : g_lat1
      assign pipe_d = sel ? 1'b0 : pipe_in;
    end else begin : g_latn
      assign pipe_d = sel ? '0 : {pipe_q[LATENCY-2:0], pipe_in};
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q   <= ST_IDLE;
        count_q   <= '0;
        period_q  <= '0;
        oneshot_q <= 1'b0;
        pipe_q    <= '0;
      end else begin
        state_q   <= state_d;
        count_q   <= count_d;
        period_q  <= period_d;
        oneshot_q <= oneshot_d;
        pipe_q    <= pipe_d;
      end
    end

    assign strobe_o[c] = pipe_q[LATENCY-1];
    assign armed_o[c]  = (state_q == ST_RUN);
  end

endmodule
`default_nettype wire

// File: tb/tb_counter_strobe_multi.sv
`default_nettype none
// Testbench for counter_strobe_multi: directed scenario with literal
// expectations, then randomized traffic checked against a queue-based model.
module tb_counter_strobe_multi;
  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int LAT   = 2;
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NCH-1:0]   tick = '1;
  logic             cfg_valid = 1'b0;
  logic [CH_W-1:0]  cfg_ch = '0;
  logic [WIDTH-1:0] cfg_period = '0;
  logic             cfg_oneshot = 1'b0;
  logic             cfg_ready;
  logic [NCH-1:0]   strobe;
  logic [NCH-1:0]   armed;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_strobe_multi #(
    .WIDTH    (WIDTH),
    .CHANNELS (NCH),
    .LATENCY  (LAT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .tick_i        (tick),
    .cfg_valid_i   (cfg_valid),
    .cfg_ready_o   (cfg_ready),
    .cfg_ch_i      (cfg_ch),
    .cfg_period_i  (cfg_period),
    .cfg_oneshot_i (cfg_oneshot),
    .strobe_o      (strobe),
    .armed_o       (armed)
  );

  task automatic chk(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, n, act, exp);
    end
  endtask

  // Reference model: ticks counted since configuration, strobes kept as due cycles.
  int unsigned m_period [NCH];
  bit          m_one    [NCH];
  bit          m_run    [NCH];
  int unsigned m_n      [NCH];
  int          due_q    [NCH][$];
  bit          m_ready = 1'b0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      m_ready = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        m_period[c] = 0;
        m_one[c]    = 1'b0;
        m_run[c]    = 1'b0;
        m_n[c]      = 0;
        due_q[c].delete();
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (cfg_valid && m_ready && int'(cfg_ch) == c) begin
          m_period[c] = cfg_period;
          m_one[c]    = cfg_oneshot;
          m_n[c]      = 0;
          m_run[c]    = (cfg_period != 0);
          due_q[c].delete();
        end else if (m_run[c] && tick[c]) begin
          m_n[c] = m_n[c] + 1;
          if (m_n[c] % m_period[c] == 0) begin
            due_q[c].push_back(cyc + LAT - 1);
            if (m_one[c]) m_run[c] = 1'b0;
          end
        end
      end
      m_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    logic [NCH-1:0] es;
    logic [NCH-1:0] ea;
    for (int c = 0; c < NCH; c++) begin
      while (due_q[c].size() > 0 && due_q[c][0] < cyc) void'(due_q[c].pop_front());
      es[c] = (due_q[c].size() > 0 && due_q[c][0] == cyc);
      ea[c] = m_run[c];
    end
    chk("model_ready",  cyc, 32'(cfg_ready), 32'(m_ready));
    chk("model_strobe", cyc, 32'(strobe),    32'(es));
    chk("model_armed",  cyc, 32'(armed),     32'(ea));
  end

  task automatic goto(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic do_cfg(input int ch, input int per, input bit os);
    cfg_valid   = 1'b1;
    cfg_ch      = CH_W'(ch);
    cfg_period  = WIDTH'(per);
    cfg_oneshot = os;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NCH-1:0] exp_s;
    logic [NCH-1:0] exp_a;
    logic           exp_r;

    for (int n = 1; n <= 55; n++) begin
      goto(n);
      rst = (n <= 1) || (n == 51);
      if (n <= 4) begin
        tick = '1;
      end else begin
        tick[0] = (n == 10) || (n == 12) || (n == 13) || (n == 50);
        tick[1] = (n >= 10 && n <= 18) || (n == 41) || (n >= 43 && n <= 49);
        tick[2] = (n >= 10 && n <= 40);
        tick[3] = (n >= 10 && n <= 15);
      end
      cfg_valid = 1'b0;
      case (n)
        5:       do_cfg(1, 3, 1'b0);
        6:       do_cfg(2, 5, 1'b1);
        7:       do_cfg(0, 1, 1'b0);
        8:       do_cfg(3, 4, 1'b0);
        13:      do_cfg(3, 2, 1'b0);
        42:      do_cfg(1, 0, 1'b0);
        default: ;
      endcase

      case (n)
        12:      exp_s = 4'b0001;
        14:      exp_s = 4'b0011;
        15:      exp_s = 4'b0001;
        16:      exp_s = 4'b0100;
        17:      exp_s = 4'b1010;
        20:      exp_s = 4'b0010;
        default: exp_s = 4'b0000;
      endcase
      exp_a = {(n >= 9 && n <= 51), (n >= 7 && n <= 14), (n >= 6 && n <= 42), (n >= 8 && n <= 51)};
      exp_r = !((n <= 2) || (n == 52));
      chk("lit_strobe", n, 32'(strobe),    32'(exp_s));
      chk("lit_armed",  n, 32'(armed),     32'(exp_a));
      chk("lit_ready",  n, 32'(cfg_ready), 32'(exp_r));
    end

    for (int n = 56; n < 3056; n++) begin
      goto(n);
      rst  = ($urandom_range(0, 249) == 0);
      tick = NCH'($urandom);
      if ($urandom_range(0, 3) == 0) tick = '1;
      cfg_valid   = ($urandom_range(0, 4) == 0);
      cfg_ch      = CH_W'($urandom_range(0, NCH - 1));
      cfg_period  = ($urandom_range(0, 7) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 6));
      cfg_oneshot = 1'($urandom_range(0, 1));
    end

    goto(3056);
    rst       = 1'b0;
    tick      = '0;
    cfg_valid = 1'b0;
    goto(3062);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
